sensor_interface: RTL and testbench

//  Front-end conditioning block for one 16-bit sensor channel; sits between the sensor capture

---
 rtl/sensor_interface.sv | 72 +++++++
 tb/tb_sensor_interface.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/sensor_interface.sv
// One-channel sensor conditioner: 2**AVG_LOG2-deep moving average with a
// hysteresis comparator on the filtered value. All outputs registered.
module sensor_interface #(
  parameter int                DATA_W    = 16,
  parameter int                AVG_LOG2  = 2,
  parameter logic [DATA_W-1:0] THRESH_HI = 16'h0060,
  parameter logic [DATA_W-1:0] THRESH_LO = 16'h0030
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] sensor_data,
  input  logic              data_valid,
  output logic [DATA_W-1:0] processed_data,
  output logic              decision
);

  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int SUM_W = DATA_W + AVG_LOG2;

  logic [DATA_W-1:0] r_win [DEPTH];
  logic [SUM_W-1:0]  r_sum;
  logic [DATA_W-1:0] r_avg;
  logic              r_dec;

  logic [SUM_W-1:0]  w_sum_next;
  logic [DATA_W-1:0] w_avg_next;
  logic              w_dec_next;

  // Sum is wide enough for DEPTH full-scale samples, so add/subtract never wraps.
  assign w_sum_next = r_sum - SUM_W'(r_win[DEPTH-1]) + SUM_W'(sensor_data);
  assign w_avg_next = DATA_W'(w_sum_next >> AVG_LOG2);

  // Hysteresis decision on the average produced at this edge.
  always_comb begin
    w_dec_next = r_dec;
    if (w_avg_next >= THRESH_HI) begin
      w_dec_next = 1'b1;
    end else if (w_avg_next < THRESH_LO) begin
      w_dec_next = 1'b0;
    end else begin
      w_dec_next = r_dec;
    end
  end

  // Window shift, running sum and registered outputs; all hold while data_valid is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_win[i] <= {DATA_W{1'b0}};
      end
      r_sum <= {SUM_W{1'b0}};
      r_avg <= {DATA_W{1'b0}};
      r_dec <= 1'b0;
    end else if (data_valid) begin
      r_win[0] <= sensor_data;
      for (int i = 1; i < DEPTH; i++) begin
        r_win[i] <= r_win[i-1];
      end
      r_sum <= w_sum_next;
      r_avg <= w_avg_next;
      r_dec <= w_dec_next;
    end else begin
      r_sum <= r_sum;
      r_avg <= r_avg;
      r_dec <= r_dec;
    end
  end

  assign processed_data = r_avg;
  assign decision       = r_dec;

endmodule

// File: tb/tb_sensor_interface.sv
// Scoreboard bench for sensor_interface: directed samples push hand-computed
// expectations; a monitor pops and checks after each accepting edge.
module tb_sensor_interface;

  logic        clk;
  logic        rst;
  logic [15:0] sensor_data;
  logic        data_valid;
  logic [15:0] processed_data;
  logic        decision;

  int n_cmp;
  int n_bad;

  logic [16:0] exp_q [$];
  logic [16:0] last_exp;

  sensor_interface dut (
    .clk            (clk),
    .rst            (rst),
    .sensor_data    (sensor_data),
    .data_valid     (data_valid),
    .processed_data (processed_data),
    .decision       (decision)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [16:0] act, input logic [16:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got data=%h dec=%b, expected data=%h dec=%b",
               name, act[16:1], act[0], exp[16:1], exp[0]);
    end
  endtask

  // Monitor: after an accepting edge pop and compare; on idle edges check outputs hold.
  initial begin
    logic v_s;
    logic r_s;
    logic [16:0] e;
    last_exp = 17'h0;
    forever begin
      @(posedge clk);
      v_s = data_valid;
      r_s = rst;
      #1;
      if (r_s || rst) begin
        last_exp = 17'h0;
      end else if (v_s) begin
        if (exp_q.size() == 0) begin
          check("unexpected_sample", {processed_data, decision}, 17'h1ffff);
        end else begin
          e = exp_q.pop_front();
          check("sample", {processed_data, decision}, e);
          last_exp = e;
        end
      end else begin
        check("hold", {processed_data, decision}, last_exp);
      end
    end
  end

  task automatic drive(input logic [15:0] d, input logic [15:0] ed, input logic edc);
    @(negedge clk);
    sensor_data = d;
    data_valid  = 1'b1;
    exp_q.push_back({ed, edc});
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      data_valid  = 1'b0;
      sensor_data = 16'h0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    data_valid = 1'b0;
    sensor_data = 16'h0;
    #1;
    check("reset_state", {processed_data, decision}, 17'h0);
    #9;
    rst = 1'b0;
    idle(3);

    drive(16'h0020, 16'h0008, 1'b0); idle(2);
    drive(16'h0080, 16'h0028, 1'b0); idle(2);
    drive(16'h0000, 16'h0028, 1'b0); idle(2);
    drive(16'h00FF, 16'h0067, 1'b1); idle(2);

    drive(16'h0040, 16'h006F, 1'b1);
    drive(16'h0050, 16'h0063, 1'b1);
    drive(16'h0060, 16'h007B, 1'b1);

    // Window is now FF,40,50,60 (sum 0x1EF).
    drive(16'h0000, 16'h003C, 1'b1);
    drive(16'h0000, 16'h002C, 1'b0);
    drive(16'h0000, 16'h0018, 1'b0);
    drive(16'h0000, 16'h0000, 1'b0);
    idle(2);

    drive(16'hFFFF, 16'h3FFF, 1'b1);
    drive(16'hFFFF, 16'h7FFF, 1'b1);
    drive(16'hFFFF, 16'hBFFF, 1'b1);
    drive(16'hFFFF, 16'hFFFF, 1'b1);
    idle(2);
    drive(16'h0000, 16'hBFFF, 1'b1);
    idle(2);

    #2;
    rst = 1'b1;
    #1;
    check("async_reset", {processed_data, decision}, 17'h0);
    idle(2);
    rst = 1'b0;
    idle(1);
    drive(16'h0040, 16'h0010, 1'b0);
    idle(3);

    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
